// File: rtl/butterfly_stage_sink_if.sv
// Beat bus from the 8-lane butterfly stage plus the single-point read port of the frame store.
interface butterfly_stage_sink_if #(
    parameter int TOTALBITS = 30,
    parameter int ADDRBITS  = 8
);
    logic                        startin;
    logic [ADDRBITS-1:0]         addr_in_0, addr_in_1, addr_in_2, addr_in_3;
    logic [ADDRBITS-1:0]         addr_in_4, addr_in_5, addr_in_6, addr_in_7;
    logic signed [TOTALBITS-1:0] realin_0, realin_1, realin_2, realin_3;
    logic signed [TOTALBITS-1:0] realin_4, realin_5, realin_6, realin_7;
    logic signed [TOTALBITS-1:0] imagin_0, imagin_1, imagin_2, imagin_3;
    logic signed [TOTALBITS-1:0] imagin_4, imagin_5, imagin_6, imagin_7;
    logic                        rd_en;
    logic [ADDRBITS-1:0]         rd_addr;
    logic signed [TOTALBITS-1:0] rd_real;
    logic signed [TOTALBITS-1:0] rd_imag;
    logic                        rd_valid;

    modport master (
        output startin,
        output addr_in_0, addr_in_1, addr_in_2, addr_in_3,
        output addr_in_4, addr_in_5, addr_in_6, addr_in_7,
        output realin_0, realin_1, realin_2, realin_3,
        output realin_4, realin_5, realin_6, realin_7,
        output imagin_0, imagin_1, imagin_2, imagin_3,
        output imagin_4, imagin_5, imagin_6, imagin_7,
        output rd_en, rd_addr,
        input  rd_real, rd_imag, rd_valid
    );

    modport slave (
        input  startin,
        input  addr_in_0, addr_in_1, addr_in_2, addr_in_3,
        input  addr_in_4, addr_in_5, addr_in_6, addr_in_7,
        input  realin_0, realin_1, realin_2, realin_3,
        input  realin_4, realin_5, realin_6, realin_7,
        input  imagin_0, imagin_1, imagin_2, imagin_3,
        input  imagin_4, imagin_5, imagin_6, imagin_7,
        input  rd_en, rd_addr,
        output rd_real, rd_imag, rd_valid
    );
endinterface

// File: rtl/butterfly_stage_sink.sv
// Scatters 8-lane butterfly beats into a 256-point complex frame store, counts beats
// until the frame is complete, and serves registered single-point reads.
module butterfly_stage_sink #(
    parameter int TOTALBITS = 30,
    parameter int ADDRBITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    butterfly_stage_sink_if.slave bus,
    output logic [5:0]            group_count,
    output logic                  stage_done,
    output logic                  frame_full,
    output logic                  overflow,
    output logic                  dup_err
);
    localparam int LANES  = 8;
    localparam int DEPTH  = 2 ** ADDRBITS;
    localparam int GROUPS = DEPTH / LANES;
    localparam logic [5:0] LAST_BEAT = 6'(GROUPS - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [5:0]                  r_count;
    logic                        r_stage_done;
    logic                        r_overflow;
    logic                        r_dup_err;
    logic [2*TOTALBITS-1:0]      r_mem [DEPTH];
    logic signed [TOTALBITS-1:0] r_rd_real_p1;
    logic signed [TOTALBITS-1:0] r_rd_imag_p1;
    logic                        r_rd_vld_p1;

    logic [ADDRBITS-1:0]         w_addr [LANES];
    logic signed [TOTALBITS-1:0] w_re   [LANES];
    logic signed [TOTALBITS-1:0] w_im   [LANES];
    logic                        w_beat;
    logic                        w_last;
    logic                        w_blocked;
    logic                        w_dup;

    assign w_addr[0] = bus.addr_in_0;
    assign w_addr[1] = bus.addr_in_1;
    assign w_addr[2] = bus.addr_in_2;
    assign w_addr[3] = bus.addr_in_3;
    assign w_addr[4] = bus.addr_in_4;
    assign w_addr[5] = bus.addr_in_5;
    assign w_addr[6] = bus.addr_in_6;
    assign w_addr[7] = bus.addr_in_7;
    assign w_re[0]   = bus.realin_0;
    assign w_re[1]   = bus.realin_1;
    assign w_re[2]   = bus.realin_2;
    assign w_re[3]   = bus.realin_3;
    assign w_re[4]   = bus.realin_4;
    assign w_re[5]   = bus.realin_5;
    assign w_re[6]   = bus.realin_6;
    assign w_re[7]   = bus.realin_7;
    assign w_im[0]   = bus.imagin_0;
    assign w_im[1]   = bus.imagin_1;
    assign w_im[2]   = bus.imagin_2;
    assign w_im[3]   = bus.imagin_3;
    assign w_im[4]   = bus.imagin_4;
    assign w_im[5]   = bus.imagin_5;
    assign w_im[6]   = bus.imagin_6;
    assign w_im[7]   = bus.imagin_7;

    // clear outranks a coincident beat, so the beat is neither stored nor counted
    assign w_beat    = bus.startin && !clear && (r_state != FULL);
    assign w_last    = w_beat && (r_count == LAST_BEAT);
    assign w_blocked = bus.startin && !clear && (r_state == FULL);

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < LANES - 1; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (w_addr[i] == w_addr[j]) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (bus.startin) w_state_nxt = FILL;
                FILL:    if (w_last)      w_state_nxt = FULL;
                FULL:    w_state_nxt = FULL;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_stage_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_dup_err    <= 1'b0;
        end else if (clear) begin
            r_count      <= '0;
            r_stage_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_dup_err    <= 1'b0;
        end else begin
            if (w_beat) begin
                r_count <= r_count + 6'd1;
            end
            r_stage_done <= w_last;
            if (w_blocked) begin
                r_overflow <= 1'b1;
            end
            if (w_beat && w_dup) begin
                r_dup_err <= 1'b1;
            end
        end
    end

    // Lanes are written in ascending order so the highest lane wins an address clash
    always_ff @(posedge clk) begin
        if (w_beat) begin
            for (int i = 0; i < LANES; i++) begin
                r_mem[w_addr[i]] <= {w_re[i], w_im[i]};
            end
        end
    end

    // p0 -> p1: read port; store is sampled before this edge's write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_real_p1 <= '0;
            r_rd_imag_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_real_p1 <= r_mem[bus.rd_addr][2*TOTALBITS-1:TOTALBITS];
                r_rd_imag_p1 <= r_mem[bus.rd_addr][TOTALBITS-1:0];
            end
        end
    end

    assign bus.rd_real  = r_rd_real_p1;
    assign bus.rd_imag  = r_rd_imag_p1;
    assign bus.rd_valid = r_rd_vld_p1;
    assign group_count  = r_count;
    assign stage_done   = r_stage_done;
    assign frame_full   = (r_state == FULL);
    assign overflow     = r_overflow;
    assign dup_err      = r_dup_err;
endmodule

// File: tb/tb_butterfly_stage_sink.sv
// Randomized bench for butterfly_stage_sink against a beat-level frame-store model.
module tb_butterfly_stage_sink;
    localparam int TB_W = 30;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [5:0] group_count;
    logic       stage_done;
    logic       frame_full;
    logic       overflow;
    logic       dup_err;

    butterfly_stage_sink_if #(.TOTALBITS(TB_W), .ADDRBITS(8)) bif ();

    butterfly_stage_sink #(.TOTALBITS(TB_W), .ADDRBITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bif),
        .group_count(group_count),
        .stage_done (stage_done),
        .frame_full (frame_full),
        .overflow   (overflow),
        .dup_err    (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pulses = 0;

    // stimulus for the next edge
    logic                   t_start, t_clr, t_rd_en;
    logic [7:0]             t_rd_addr;
    logic [7:0]             l_addr [8];
    logic signed [TB_W-1:0] l_re   [8];
    logic signed [TB_W-1:0] l_im   [8];

    // reference model: frame contents and beat bookkeeping
    logic signed [TB_W-1:0] m_re [256];
    logic signed [TB_W-1:0] m_im [256];
    bit                     m_known [256];
    int                     m_count;
    bit                     m_done, m_ovf, m_dup;
    bit                     exp_vld, exp_known;
    logic signed [TB_W-1:0] exp_re, exp_im;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 8; i++) begin
            l_addr[i] = 8'($urandom);
            l_re[i]   = TB_W'($urandom);
            l_im[i]   = TB_W'($urandom);
        end
    endtask

    task automatic step();
        clear         = t_clr;
        bif.startin   = t_start;
        bif.rd_en     = t_rd_en;
        bif.rd_addr   = t_rd_addr;
        bif.addr_in_0 = l_addr[0]; bif.realin_0 = l_re[0]; bif.imagin_0 = l_im[0];
        bif.addr_in_1 = l_addr[1]; bif.realin_1 = l_re[1]; bif.imagin_1 = l_im[1];
        bif.addr_in_2 = l_addr[2]; bif.realin_2 = l_re[2]; bif.imagin_2 = l_im[2];
        bif.addr_in_3 = l_addr[3]; bif.realin_3 = l_re[3]; bif.imagin_3 = l_im[3];
        bif.addr_in_4 = l_addr[4]; bif.realin_4 = l_re[4]; bif.imagin_4 = l_im[4];
        bif.addr_in_5 = l_addr[5]; bif.realin_5 = l_re[5]; bif.imagin_5 = l_im[5];
        bif.addr_in_6 = l_addr[6]; bif.realin_6 = l_re[6]; bif.imagin_6 = l_im[6];
        bif.addr_in_7 = l_addr[7]; bif.realin_7 = l_re[7]; bif.imagin_7 = l_im[7];

        // reads see the frame as it was before this edge's beat
        if (t_rd_en) begin
            exp_vld   = 1'b1;
            exp_known = m_known[t_rd_addr];
            exp_re    = m_re[t_rd_addr];
            exp_im    = m_im[t_rd_addr];
        end else begin
            exp_vld = 1'b0;
        end

        if (t_clr) begin
            m_count = 0; m_done = 0; m_ovf = 0; m_dup = 0;
        end else if (t_start && m_count == 32) begin
            m_ovf = 1; m_done = 0;
        end else if (t_start) begin
            for (int i = 0; i < 8; i++)
                for (int j = i + 1; j < 8; j++)
                    if (l_addr[i] == l_addr[j]) m_dup = 1;
            for (int i = 0; i < 8; i++) begin
                m_re[l_addr[i]]    = l_re[i];
                m_im[l_addr[i]]    = l_im[i];
                m_known[l_addr[i]] = 1'b1;
            end
            m_count++;
            m_done = (m_count == 32);
        end else begin
            m_done = 0;
        end

        @(posedge clk);
        #1;
        chk("group_count", 64'(group_count), 64'(m_count));
        chk("frame_full",  64'(frame_full),  64'(m_count == 32));
        chk("stage_done",  64'(stage_done),  64'(m_done));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("dup_err",     64'(dup_err),     64'(m_dup));
        chk("rd_valid",    64'(bif.rd_valid), 64'(exp_vld));
        if (exp_known) begin
            chk("rd_real", 64'(bif.rd_real), 64'(exp_re));
            chk("rd_imag", 64'(bif.rd_imag), 64'(exp_im));
        end
        if (stage_done) n_pulses++;
        t_start = 1'b0; t_clr = 1'b0; t_rd_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"},  64'(group_count),  64'd0);
        chk({tag, "_done"}, 64'(stage_done),   64'd0);
        chk({tag, "_full"}, 64'(frame_full),   64'd0);
        chk({tag, "_ovf"},  64'(overflow),     64'd0);
        chk({tag, "_dup"},  64'(dup_err),      64'd0);
        chk({tag, "_vld"},  64'(bif.rd_valid), 64'd0);
        chk({tag, "_re"},   64'(bif.rd_real),  64'd0);
        chk({tag, "_im"},   64'(bif.rd_imag),  64'd0);
    endtask

    task automatic model_reset();
        m_count = 0; m_done = 0; m_ovf = 0; m_dup = 0;
        exp_vld = 0; exp_known = 1; exp_re = '0; exp_im = '0;
        for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; t_start = 0; t_clr = 0; t_rd_en = 0; t_rd_addr = '0;
        for (int i = 0; i < 8; i++) begin l_addr[i] = '0; l_re[i] = '0; l_im[i] = '0; end
        clear = 1'b0; bif.startin = 1'b0; bif.rd_en = 1'b0; bif.rd_addr = '0;
        model_reset();

        // reset state, then a reset asserted in the middle of a partial frame
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_init");
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin rand_lanes(); t_start = 1; t_rd_en = 1; step(); end
        #2; rst_n = 1'b0; #1;
        chk_all_zero("rst_mid");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step();

        // full frame: lane N of beat g at 8g+N, real=8g+N, imag=-(8g+N), with idle gaps
        n_pulses = 0;
        for (int g = 0; g < 32; g++) begin
            repeat ($urandom_range(0, 2)) begin
                t_rd_en = 1'($urandom); t_rd_addr = 8'($urandom); step();
            end
            for (int n = 0; n < 8; n++) begin
                l_addr[n] = 8'(8 * g + n);
                l_re[n]   = TB_W'(8 * g + n);
                l_im[n]   = TB_W'(-(8 * g + n));
            end
            t_start = 1; step();
        end
        step();
        chk("done_pulses", 64'(n_pulses), 64'd1);
        chk("full_after_32", 64'(frame_full), 64'd1);
        for (int a = 0; a < 256; a++) begin
            t_rd_en = 1; t_rd_addr = 8'(a); step();
            chk("frame_re", 64'(bif.rd_real), 64'(a));
            chk("frame_im", 64'(bif.rd_imag), 64'(-a));
        end
        step();

        // beat while full: dropped, overflow sticks
        rand_lanes(); l_addr[0] = 8'd5; l_re[0] = TB_W'(999);
        t_start = 1; step();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(group_count), 64'd32);
        t_rd_en = 1; t_rd_addr = 8'd5; step();
        chk("ovf_mem5", 64'(bif.rd_real), 64'd5);

        // duplicate address inside one beat: higher lane wins
        t_clr = 1; step();
        rand_lanes();
        for (int i = 0; i < 8; i++) l_addr[i] = 8'(100 + i);
        l_addr[2] = 8'd17; l_re[2] = TB_W'(100);
        l_addr[6] = 8'd17; l_re[6] = TB_W'(600);
        t_start = 1; step();
        chk("dup_flag", 64'(dup_err), 64'd1);
        chk("dup_count", 64'(group_count), 64'd1);
        t_rd_en = 1; t_rd_addr = 8'd17; step();
        chk("dup_rd", 64'(bif.rd_real), 64'd600);

        // same-edge read and write of address 40
        rand_lanes();
        for (int i = 0; i < 8; i++) l_addr[i] = 8'(50 + i);
        l_addr[0] = 8'd40; l_re[0] = TB_W'(4040);
        t_start = 1; t_rd_en = 1; t_rd_addr = 8'd40; step();
        chk("rw_old", 64'(bif.rd_real), 64'd40);
        t_rd_en = 1; t_rd_addr = 8'd40; step();
        chk("rw_new", 64'(bif.rd_real), 64'd4040);

        // clear with a coincident beat at group_count=10
        t_clr = 1; step();
        for (int k = 0; k < 10; k++) begin
            rand_lanes();
            if (k == 3) l_addr[5] = l_addr[1];
            t_start = 1; step();
        end
        chk("pre_clr_cnt", 64'(group_count), 64'd10);
        chk("pre_clr_dup", 64'(dup_err), 64'd1);
        rand_lanes(); t_clr = 1; t_start = 1; step();
        chk("clr_cnt", 64'(group_count), 64'd0);
        chk("clr_dup", 64'(dup_err), 64'd0);
        step();

        // random traffic
        repeat (1500) begin
            rand_lanes();
            t_start   = ($urandom_range(0, 9) < 6);
            t_clr     = ($urandom_range(0, 149) == 0);
            t_rd_en   = 1'($urandom);
            t_rd_addr = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
